// File: rtl/irq_prio_ctrl_if.sv
// Bus between the interrupt controller and its surroundings: peripheral IRQ lines, mask,
// CPU IACK/EOI pulses, and the registered request and status seen by the CPU.
interface irq_prio_ctrl_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IDW = $clog2(NCH)
);
    logic [NCH-1:0] irq;
    logic [NCH-1:0] mask;
    logic           iack;
    logic           eoi;
    logic           int_req;
    logic [IDW-1:0] int_id;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] in_service;

    modport master (
        output irq, mask, iack, eoi,
        input  int_req, int_id, pending, in_service
    );

    modport slave (
        input  irq, mask, iack, eoi,
        output int_req, int_id, pending, in_service
    );
endinterface

// File: rtl/irq_prio_ctrl.sv
// Fixed-priority interrupt controller: edge/level latching, masking, registered request to
// the CPU and an IACK/EOI in-service register with optional nested preemption.
module irq_prio_ctrl #(
    parameter int unsigned    NCH  = 4,
    parameter int unsigned    IDW  = $clog2(NCH),
    parameter logic [NCH-1:0] EDGE = {NCH{1'b1}},
    parameter bit             NEST = 1'b0
) (
    input logic            clk,
    input logic            rst,
    irq_prio_ctrl_if.slave bus
);
    logic [NCH-1:0] irq_q;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] in_service_q, in_service_d;
    logic           int_req_q, int_req_d;
    logic [IDW-1:0] int_id_q, int_id_d;

    logic [NCH-1:0] eligible, set_vec, ack_vec, top_vec, eoi_vec;
    logic [IDW-1:0] best, top_is;
    logic           any_elig, any_is, iack_acc, prio_ok;

    assign eligible = pending_q & ~bus.mask;
    assign any_elig = |eligible;
    assign any_is   = |in_service_q;
    assign iack_acc = bus.iack & int_req_q;

    // Level channels set every cycle the line is high; edge channels only on a 0->1 step.
    assign set_vec = bus.irq & (~EDGE | ~irq_q);
    assign ack_vec = iack_acc ? (NCH'(1) << int_id_q) : '0;
    assign top_vec = in_service_q & (~in_service_q + NCH'(1));
    assign eoi_vec = bus.eoi ? top_vec : '0;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        best   = '0;
        top_is = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                best = IDW'(i);
            end
            if (in_service_q[i]) begin
                top_is = IDW'(i);
            end
        end
    end

    always_comb begin
        pending_d    = (pending_q & ~ack_vec) | set_vec;
        in_service_d = (in_service_q & ~eoi_vec) | ack_vec;
        prio_ok      = ~any_is | (NEST && (best < top_is));
        int_req_d    = any_elig & prio_ok & ~iack_acc;
        int_id_d     = int_req_d ? best : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
        end else begin
            irq_q        <= bus.irq;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: three instances (plain, nested, ch2 level) against a behavioural
// model, with directed scenarios followed by randomized traffic.
module tb_irq_prio_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_v  [3];
    logic [3:0] mask_v [3];
    logic       iack_v [3];
    logic       eoi_v  [3];
    logic       req_v  [3];
    logic [1:0] id_v   [3];
    logic [3:0] pend_v [3];
    logic [3:0] isv_v  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: edge, no nesting. Instance 1: edge, nesting. Instance 2: ch2 level.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        irq_prio_ctrl_if #(.NCH(4)) bus ();
        assign bus.irq  = irq_v[g];
        assign bus.mask = mask_v[g];
        assign bus.iack = iack_v[g];
        assign bus.eoi  = eoi_v[g];
        assign req_v[g]  = bus.int_req;
        assign id_v[g]   = bus.int_id;
        assign pend_v[g] = bus.pending;
        assign isv_v[g]  = bus.in_service;
        irq_prio_ctrl #(
            .NCH (4),
            .EDGE((g == 2) ? 4'b1011 : 4'b1111),
            .NEST(g == 1)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    // Reference model state, one entry per instance.
    logic [3:0] m_irq_q [3], n_irq_q [3];
    logic [3:0] m_pend  [3], n_pend  [3];
    logic [3:0] m_isv   [3], n_isv   [3];
    logic       m_req   [3], n_req   [3];
    int         m_id    [3], n_id    [3];

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int         best, top;
        bit         acc, lvl;
        logic [3:0] p, s;
        best = lowest(m_pend[k] & ~mask_v[k]);
        top  = lowest(m_isv[k]);
        acc  = iack_v[k] && m_req[k];
        p = m_pend[k];
        s = m_isv[k];
        if (acc) p[m_id[k]] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lvl = (k == 2) && (i == 2);
            if (irq_v[k][i] && (lvl || !m_irq_q[k][i])) p[i] = 1'b1;
        end
        if (eoi_v[k] && top >= 0) s[top] = 1'b0;
        if (acc) s[m_id[k]] = 1'b1;
        n_pend[k]  = p;
        n_isv[k]   = s;
        n_irq_q[k] = irq_v[k];
        n_req[k]   = (best >= 0) && !acc && (top < 0 || (k == 1 && best < top));
        n_id[k]    = n_req[k] ? best : 0;
    endtask

    // Advance one clock: model computed from stable inputs, DUT sampled at the falling edge.
    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_irq_q[k] = '0; m_pend[k] = '0; m_isv[k] = '0; m_req[k] = 1'b0; m_id[k] = 0;
            end else begin
                m_irq_q[k] = n_irq_q[k]; m_pend[k] = n_pend[k]; m_isv[k] = n_isv[k];
                m_req[k] = n_req[k]; m_id[k] = n_id[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_iack(input int k);
        iack_v[k] = 1'b1; tick(); iack_v[k] = 1'b0;
    endtask

    task automatic pulse_eoi(input int k);
        eoi_v[k] = 1'b1; tick(); eoi_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({req_v[k], id_v[k], pend_v[k], isv_v[k]} !== 11'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got req=%b id=%0d pend=%b isv=%b want all 0",
                         k, req_v[k], id_v[k], pend_v[k], isv_v[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        irq_v[0] = 4'b0100;
        tick();
        checks++;
        if ({pend_v[0], req_v[0]} !== 5'b0100_0) begin
            errors++; $display("FAIL basic_pend: got pend=%b req=%b want 0100/0", pend_v[0], req_v[0]);
        end
        tick();
        checks++;
        if ({req_v[0], id_v[0]} !== 3'b1_10) begin
            errors++; $display("FAIL basic_req: got req=%b id=%0d want 1/2", req_v[0], id_v[0]);
        end
        tick();
        pulse_iack(0);
        checks++;
        if ({pend_v[0], isv_v[0], req_v[0]} !== 9'b0000_0100_0) begin
            errors++;
            $display("FAIL basic_iack: got pend=%b isv=%b req=%b want 0000/0100/0",
                     pend_v[0], isv_v[0], req_v[0]);
        end
        irq_v[0] = 4'b0000;
        tick();
        tick();
        pulse_eoi(0);
        checks++;
        if (isv_v[0] !== 4'b0000) begin
            errors++; $display("FAIL basic_eoi: got isv=%b want 0000", isv_v[0]);
        end
    endtask

    task automatic test_simultaneous();
        irq_v[0] = 4'b1010;
        tick();
        tick();
        checks++;
        if ({req_v[0], id_v[0]} !== 3'b1_01) begin
            errors++; $display("FAIL simul_first: got req=%b id=%0d want 1/1", req_v[0], id_v[0]);
        end
        pulse_iack(0);
        checks++;
        if ({isv_v[0], pend_v[0]} !== 8'b0010_1000) begin
            errors++;
            $display("FAIL simul_iack: got isv=%b pend=%b want 0010/1000", isv_v[0], pend_v[0]);
        end
        pulse_eoi(0);
        checks++;
        if (req_v[0] !== 1'b0) begin
            errors++; $display("FAIL simul_eoi_edge: got req=%b want 0", req_v[0]);
        end
        tick();
        checks++;
        if ({req_v[0], id_v[0]} !== 3'b1_11) begin
            errors++; $display("FAIL simul_second: got req=%b id=%0d want 1/3", req_v[0], id_v[0]);
        end
        pulse_iack(0);
        pulse_eoi(0);
        irq_v[0] = 4'b0000;
        tick();
    endtask

    task automatic test_mask();
        mask_v[0] = 4'b0010;
        irq_v[0]  = 4'b0010;
        tick();
        tick();
        tick();
        checks++;
        if ({pend_v[0], req_v[0]} !== 5'b0010_0) begin
            errors++;
            $display("FAIL mask_hold: got pend=%b req=%b want 0010/0", pend_v[0], req_v[0]);
        end
        mask_v[0] = 4'b0000;
        tick();
        checks++;
        if ({req_v[0], id_v[0]} !== 3'b1_01) begin
            errors++; $display("FAIL mask_release: got req=%b id=%0d want 1/1", req_v[0], id_v[0]);
        end
        pulse_iack(0);
        pulse_eoi(0);
        irq_v[0] = 4'b0000;
        tick();
    endtask

    task automatic test_nest();
        irq_v[1] = 4'b1000;
        tick();
        tick();
        pulse_iack(1);
        checks++;
        if ({isv_v[1], req_v[1]} !== 5'b1000_0) begin
            errors++; $display("FAIL nest_ack3: got isv=%b req=%b want 1000/0", isv_v[1], req_v[1]);
        end
        irq_v[1] = 4'b1001;
        tick();
        tick();
        checks++;
        if ({req_v[1], id_v[1]} !== 3'b1_00) begin
            errors++; $display("FAIL nest_preempt: got req=%b id=%0d want 1/0", req_v[1], id_v[1]);
        end
        pulse_iack(1);
        checks++;
        if (isv_v[1] !== 4'b1001) begin
            errors++; $display("FAIL nest_isv2: got isv=%b want 1001", isv_v[1]);
        end
        pulse_eoi(1);
        checks++;
        if (isv_v[1] !== 4'b1000) begin
            errors++; $display("FAIL nest_eoi1: got isv=%b want 1000", isv_v[1]);
        end
        irq_v[1] = 4'b0001;
        tick();
        irq_v[1] = 4'b1001;
        tick();
        tick();
        tick();
        checks++;
        if ({pend_v[1], req_v[1]} !== 5'b1000_0) begin
            errors++;
            $display("FAIL nest_self_block: got pend=%b req=%b want 1000/0", pend_v[1], req_v[1]);
        end
        pulse_eoi(1);
        tick();
        checks++;
        if ({isv_v[1], req_v[1], id_v[1]} !== 7'b0000_1_11) begin
            errors++;
            $display("FAIL nest_rereq3: got isv=%b req=%b id=%0d want 0000/1/3",
                     isv_v[1], req_v[1], id_v[1]);
        end
        pulse_iack(1);
        irq_v[1] = 4'b1000;
        tick();
        irq_v[1] = 4'b1001;
        tick();
        tick();
        // Acknowledge ch0 and end ch3 in the same cycle.
        iack_v[1] = 1'b1;
        eoi_v[1]  = 1'b1;
        tick();
        iack_v[1] = 1'b0;
        eoi_v[1]  = 1'b0;
        checks++;
        if (isv_v[1] !== 4'b0001) begin
            errors++; $display("FAIL nest_iack_eoi: got isv=%b want 0001", isv_v[1]);
        end
        pulse_eoi(1);
        checks++;
        if (isv_v[1] !== 4'b0000) begin
            errors++; $display("FAIL nest_final_eoi: got isv=%b want 0000", isv_v[1]);
        end
        irq_v[1] = 4'b0000;
        tick();
    endtask

    task automatic test_level();
        irq_v[2] = 4'b0100;
        tick();
        tick();
        checks++;
        if ({req_v[2], id_v[2]} !== 3'b1_10) begin
            errors++; $display("FAIL level_req: got req=%b id=%0d want 1/2", req_v[2], id_v[2]);
        end
        pulse_iack(2);
        tick();
        tick();
        checks++;
        if ({pend_v[2], isv_v[2], req_v[2]} !== 9'b0100_0100_0) begin
            errors++;
            $display("FAIL level_repend: got pend=%b isv=%b req=%b want 0100/0100/0",
                     pend_v[2], isv_v[2], req_v[2]);
        end
        pulse_eoi(2);
        tick();
        checks++;
        if ({req_v[2], id_v[2]} !== 3'b1_10) begin
            errors++; $display("FAIL level_after_eoi: got req=%b id=%0d want 1/2", req_v[2], id_v[2]);
        end
        irq_v[2] = 4'b0000;
        pulse_iack(2);
        pulse_eoi(2);
    endtask

    task automatic test_reset_and_ignored();
        irq_v[1] = 4'b0100;
        tick();
        tick();
        pulse_iack(1);
        irq_v[1] = 4'b0101;
        tick();
        tick();
        checks++;
        if ({isv_v[1], req_v[1], id_v[1]} !== 7'b0100_1_00) begin
            errors++;
            $display("FAIL midrst_setup: got isv=%b req=%b id=%0d want 0100/1/0",
                     isv_v[1], req_v[1], id_v[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_v[1], id_v[1], pend_v[1], isv_v[1]} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_async: got req=%b id=%0d pend=%b isv=%b want all 0",
                     req_v[1], id_v[1], pend_v[1], isv_v[1]);
        end
        irq_v[1] = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        mask_v[0] = 4'b0001;
        irq_v[0]  = 4'b0001;
        tick();
        pulse_iack(0);
        checks++;
        if ({pend_v[0], isv_v[0], req_v[0]} !== 9'b0001_0000_0) begin
            errors++;
            $display("FAIL ignored_iack: got pend=%b isv=%b req=%b want 0001/0000/0",
                     pend_v[0], isv_v[0], req_v[0]);
        end
        pulse_eoi(0);
        checks++;
        if ({pend_v[0], isv_v[0]} !== 8'b0001_0000) begin
            errors++;
            $display("FAIL ignored_eoi: got pend=%b isv=%b want 0001/0000", pend_v[0], isv_v[0]);
        end
        mask_v[0] = 4'b0000;
        tick();
        pulse_iack(0);
        pulse_eoi(0);
        irq_v[0] = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                irq_v[k] = irq_v[k] ^ 4'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 15) == 0) mask_v[k] = 4'($urandom & $urandom);
                iack_v[k] = m_req[k] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                eoi_v[k]  = ($urandom_range(0, 5) == 0);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (req_v[k] !== m_req[k]) begin
                    errors++;
                    $display("FAIL rand_req[%0d] c=%0d: got %b want %b", k, c, req_v[k], m_req[k]);
                end
                checks++;
                if (id_v[k] !== 2'(m_id[k])) begin
                    errors++;
                    $display("FAIL rand_id[%0d] c=%0d: got %0d want %0d", k, c, id_v[k], m_id[k]);
                end
                checks++;
                if (pend_v[k] !== m_pend[k]) begin
                    errors++;
                    $display("FAIL rand_pend[%0d] c=%0d: got %b want %b", k, c, pend_v[k], m_pend[k]);
                end
                checks++;
                if (isv_v[k] !== m_isv[k]) begin
                    errors++;
                    $display("FAIL rand_isv[%0d] c=%0d: got %b want %b", k, c, isv_v[k], m_isv[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            irq_v[k] = '0; mask_v[k] = '0; iack_v[k] = 1'b0; eoi_v[k] = 1'b0;
            m_irq_q[k] = '0; m_pend[k] = '0; m_isv[k] = '0; m_req[k] = 1'b0; m_id[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_simultaneous();
        test_mask();
        test_nest();
        test_level();
        test_reset_and_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
